// File: rtl/reg_file_wb_arb.sv
// reg_file_wb_arb: round-robin arbiter for the register file write port (optional forwarding via WB_ARB_BYPASS_EN)
module reg_file_wb_arb #(
  parameter int NUM_REQ = 3,
  parameter int DROP_W  = 8
) (
  input  logic                    wb_arb_clk,
  input  logic                    wb_arb_rst,
  input  logic                    wb_arb_stall,
  input  logic [NUM_REQ-1:0]      wb_arb_req_valid,
  input  logic [5*NUM_REQ-1:0]    wb_arb_req_id,
  input  logic [32*NUM_REQ-1:0]   wb_arb_req_data,
  output logic [NUM_REQ-1:0]      wb_arb_req_ready,
  output logic                    wb_arb_write_sig,
  output logic [4:0]              wb_arb_write_id,
  output logic [31:0]             wb_arb_write_data,
`ifdef WB_ARB_BYPASS_EN
  output logic [DROP_W-1:0]       wb_arb_drop_cnt,
  input  logic [4:0]              wb_arb_fwd_rid1,
  input  logic [4:0]              wb_arb_fwd_rid2,
  output logic                    wb_arb_fwd_hit1,
  output logic                    wb_arb_fwd_hit2,
  output logic [31:0]             wb_arb_fwd_data1,
  output logic [31:0]             wb_arb_fwd_data2
`else
  output logic [DROP_W-1:0]       wb_arb_drop_cnt
`endif
);
  localparam int PW = $clog2(NUM_REQ);
  localparam logic [PW:0] NR = (PW+1)'(NUM_REQ);
  localparam logic [PW-1:0] LAST = PW'(NUM_REQ - 1);
  logic [PW-1:0]     r_ptr;
  logic              r_sig;
  logic [4:0]        r_id;
  logic [31:0]       r_data;
  logic [DROP_W-1:0] r_drop;
  logic [PW-1:0]     w_gnt_idx;
  logic [PW-1:0]     w_nxt_ptr;
  logic [PW:0]       w_sum;
  logic [PW:0]       w_idx;
  logic              w_any;
  logic              w_go;
  logic [4:0]        w_id;
  logic [31:0]       w_data;
  // Scan from the pointer upward with wraparound; walking the offsets downward lets the nearest valid win
  always_comb begin
    w_any = 1'b0;
    w_gnt_idx = '0;
    w_sum = '0;
    w_idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_sum = {1'b0, r_ptr} + (PW+1)'(k);
      w_idx = (w_sum >= NR) ? w_sum - NR : w_sum;
      if (wb_arb_req_valid[w_idx[PW-1:0]]) begin
        w_any = 1'b1;
        w_gnt_idx = w_idx[PW-1:0];
      end
    end
  end
  assign w_go = w_any & ~wb_arb_stall & ~wb_arb_rst;
  assign wb_arb_req_ready = w_go ? (NUM_REQ'(1) << w_gnt_idx) : '0;
  assign w_nxt_ptr = (w_gnt_idx == LAST) ? '0 : w_gnt_idx + 1'b1;
  assign w_id = wb_arb_req_id[5*w_gnt_idx +: 5];
  assign w_data = wb_arb_req_data[32*w_gnt_idx +: 32];
  // Register the winning write; $zero writes are swallowed and counted instead of issued
  always_ff @(posedge wb_arb_clk) begin
    if (wb_arb_rst) begin
      r_ptr <= '0;
      r_sig <= 1'b0;
      r_id <= '0;
      r_data <= '0;
      r_drop <= '0;
    end else begin
      r_sig <= w_go && (w_id != '0);
      if (w_go) begin
        r_ptr <= w_nxt_ptr;
        if (w_id != '0) begin
          r_id <= w_id;
          r_data <= w_data;
        end else if (r_drop != '1) begin
          r_drop <= r_drop + 1'b1;
        end
      end
    end
  end
  assign wb_arb_write_sig = r_sig;
  assign wb_arb_write_id = r_id;
  assign wb_arb_write_data = r_data;
  assign wb_arb_drop_cnt = r_drop;
`ifdef WB_ARB_BYPASS_EN
  assign wb_arb_fwd_hit1 = r_sig && (r_id == wb_arb_fwd_rid1) && (wb_arb_fwd_rid1 != '0);
  assign wb_arb_fwd_hit2 = r_sig && (r_id == wb_arb_fwd_rid2) && (wb_arb_fwd_rid2 != '0);
  assign wb_arb_fwd_data1 = wb_arb_fwd_hit1 ? r_data : '0;
  assign wb_arb_fwd_data2 = wb_arb_fwd_hit2 ? r_data : '0;
`endif
endmodule

// File: tb/tb_reg_file_wb_arb.sv
// tb_reg_file_wb_arb: directed and random checks of reg_file_wb_arb against a behavioural model
module tb_reg_file_wb_arb;
  localparam int N = 3;
  logic            clk = 1'b0;
  logic            rst;
  logic            stall;
  logic [N-1:0]    valid;
  logic [5*N-1:0]  ids;
  logic [32*N-1:0] datas;
  logic [N-1:0]    ready;
  logic            wsig;
  logic [4:0]      wid;
  logic [31:0]     wdata;
  logic [7:0]      drop;
  int n_asrt = 0;
  int n_fail = 0;
  int m_ptr = 0;
  bit m_sig = 0;
  int m_id = 0;
  logic [31:0] m_data = '0;
  int m_drop = 0;
`ifdef WB_ARB_BYPASS_EN
  logic [4:0]  rid1, rid2;
  logic        hit1, hit2;
  logic [31:0] fdata1, fdata2;
`endif
  always #5 clk = ~clk;
  reg_file_wb_arb #(.NUM_REQ(N), .DROP_W(8)) dut (
    .wb_arb_clk(clk),
    .wb_arb_rst(rst),
    .wb_arb_stall(stall),
    .wb_arb_req_valid(valid),
    .wb_arb_req_id(ids),
    .wb_arb_req_data(datas),
    .wb_arb_req_ready(ready),
    .wb_arb_write_sig(wsig),
    .wb_arb_write_id(wid),
    .wb_arb_write_data(wdata),
`ifdef WB_ARB_BYPASS_EN
    .wb_arb_drop_cnt(drop),
    .wb_arb_fwd_rid1(rid1),
    .wb_arb_fwd_rid2(rid2),
    .wb_arb_fwd_hit1(hit1),
    .wb_arb_fwd_hit2(hit2),
    .wb_arb_fwd_data1(fdata1),
    .wb_arb_fwd_data2(fdata2)
`else
    .wb_arb_drop_cnt(drop)
`endif
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic int model_grant(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++)
      if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction
  task automatic set_req(input int i, input int id, input logic [31:0] d);
    ids[5*i +: 5] = 5'(id);
    datas[32*i +: 32] = d;
  endtask
  task automatic cycle();
    int g;
    logic [N-1:0] er;
    #1;
    g = (rst || stall) ? -1 : model_grant(valid, m_ptr);
    er = '0;
    if (g >= 0) er[g] = 1'b1;
    chk("ready", 32'(ready), 32'(er));
    @(posedge clk);
    if (rst) begin
      m_sig = 0; m_id = 0; m_data = '0; m_ptr = 0; m_drop = 0;
    end else if (g < 0) begin
      m_sig = 0;
    end else begin
      m_ptr = (g + 1) % N;
      if (ids[5*g +: 5] == 5'd0) begin
        m_sig = 0;
        m_drop = (m_drop < 255) ? m_drop + 1 : 255;
      end else begin
        m_sig = 1;
        m_id = int'(ids[5*g +: 5]);
        m_data = datas[32*g +: 32];
      end
    end
    #1;
    chk("write_sig", 32'(wsig), 32'(m_sig));
    chk("write_id", 32'(wid), 32'(m_id));
    chk("write_data", wdata, m_data);
    chk("drop_cnt", 32'(drop), 32'(m_drop));
`ifdef WB_ARB_BYPASS_EN
    chk("fwd_hit1", 32'(hit1), 32'(m_sig && m_id == int'(rid1) && rid1 != 0));
    chk("fwd_hit2", 32'(hit2), 32'(m_sig && m_id == int'(rid2) && rid2 != 0));
    chk("fwd_data1", fdata1, (m_sig && m_id == int'(rid1) && rid1 != 0) ? m_data : 32'd0);
    chk("fwd_data2", fdata2, (m_sig && m_id == int'(rid2) && rid2 != 0) ? m_data : 32'd0);
`endif
    @(negedge clk);
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog expired before end of test");
    $fatal(1, "timeout");
  end
  initial begin
    rst = 1; stall = 0; valid = '1; ids = '0; datas = '0;
`ifdef WB_ARB_BYPASS_EN
    rid1 = 0; rid2 = 0;
`endif
    for (int i = 0; i < N; i++) set_req(i, i + 1, 32'h100 + i);
    @(negedge clk);
    // reset with all requesters valid
    cycle();
    cycle();
    rst = 0; valid = '0;
    // single requester
    valid = 3'b010; set_req(1, 5, 32'h1234);
    #1 chk("single_ready", 32'(ready), 32'h2);
    cycle();
    chk("single_sig", 32'(wsig), 32'd1);
    chk("single_id", 32'(wid), 32'd5);
    chk("single_data", wdata, 32'h1234);
    valid = '0;
    cycle();
    chk("single_sig_after", 32'(wsig), 32'd0);
    // round robin from a fresh pointer
    rst = 1; cycle(); rst = 0;
    valid = '1;
    for (int i = 0; i < N; i++) set_req(i, i + 1, 32'h200 + i);
    for (int c = 0; c < 6; c++) begin
      #1 chk("rr_grant", 32'(ready), 32'(1 << (c % 3)));
      cycle();
      chk("rr_id", 32'(wid), 32'(c % 3 + 1));
    end
    // stall after a grant to requester 0
    cycle();
    stall = 1; cycle(); cycle();
    chk("stall_sig", 32'(wsig), 32'd0);
    stall = 0;
    #1 chk("post_stall_grant", 32'(ready), 32'h2);
    cycle();
    // $zero drop and saturation
    rst = 1; cycle(); rst = 0;
    valid = 3'b001; set_req(0, 0, 32'hFFFF);
    cycle();
    chk("drop_first", 32'(drop), 32'd1);
    for (int c = 0; c < 260; c++) cycle();
    chk("drop_sat", 32'(drop), 32'd255);
    // same destination from two requesters: later grant wins
    rst = 1; cycle(); rst = 0;
    valid = 3'b011; set_req(0, 9, 32'hAAAA); set_req(1, 9, 32'hBBBB);
    cycle(); cycle();
    chk("same_dest_data", wdata, 32'hBBBB);
`ifdef WB_ARB_BYPASS_EN
    valid = 3'b001; set_req(0, 7, 32'hABCD); rid1 = 7; rid2 = 0;
    cycle();
    chk("byp_hit1", 32'(hit1), 32'd1);
    chk("byp_data1", fdata1, 32'hABCD);
    chk("byp_hit2", 32'(hit2), 32'd0);
`endif
    // random traffic
    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(0, 49) == 0);
      stall = ($urandom_range(0, 7) == 0);
      valid = N'($urandom());
      for (int i = 0; i < N; i++) set_req(i, ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 7), $urandom());
`ifdef WB_ARB_BYPASS_EN
      rid1 = 5'($urandom_range(0, 7));
      rid2 = 5'($urandom_range(0, 7));
`endif
      cycle();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end
endmodule
